id_stage: RTL



---
 rtl/id_stage.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- decode stage of the 16-bit five-stage pipeline.
//
// Decodes the IF/ID instruction, reads the 16x16 register file (with a
// write-through bypass from write-back), detects load-use and branch
// hazards, resolves BEQ/JMP redirects and holds the ID/EX pipeline register.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-low reset
//   opcode_ID, one_ID, two_ID,  instruction fields from IF/ID
//   three_ID, PC_ID
//   wb_we, wb_addr, wb_data     register file write-back port
//   mem_regwrite, mem_rd        destination of the instruction in MEM
//   Hazard                      stall fetch (combinational)
//   PCSource                    00 sequential, 01 branch, 10 jump
//   PCMux_1, PCMux_2            branch and jump targets
//   Halt                        sticky halt, cleared only by reset
//   ex_*                        registered ID/EX outputs
//   stall_count                 hazard-cycle counter (zero unless enabled)
//
// Configuration macro: ID_PERF_EN builds the saturating stall counter;
// when undefined stall_count is tied to zero.
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int NUM_REGS = 16,
  parameter bit R0_ZERO  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode_ID,
  input  logic [3:0]  one_ID,
  input  logic [3:0]  two_ID,
  input  logic [3:0]  three_ID,
  input  logic [15:0] PC_ID,
  input  logic        wb_we,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        mem_regwrite,
  input  logic [3:0]  mem_rd,
  output logic        Hazard,
  output logic [1:0]  PCSource,
  output logic [15:0] PCMux_1,
  output logic [15:0] PCMux_2,
  output logic        Halt,
  output logic [3:0]  ex_opcode,
  output logic [3:0]  ex_rd,
  output logic [15:0] ex_a,
  output logic [15:0] ex_b,
  output logic [15:0] ex_imm,
  output logic [15:0] ex_pc,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_alusrc,
  output logic [15:0] stall_count
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_AND    = 4'h2,
    OP_OR     = 4'h3,
    OP_ADDI   = 4'h4,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_BEQ    = 4'hA,
    OP_JMP    = 4'hC,
    OP_BUBBLE = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;

  logic [15:0] r_regs [NUM_REGS];
  logic        r_squash;
  logic        r_halt;

  logic [15:0] w_rOne, w_rTwo, w_rThree, w_b, w_imm;
  logic [3:0]  w_src1, w_src2, w_rd;
  logic        w_src1Valid, w_src2Valid;
  logic        w_regwrite, w_memread, w_memwrite, w_alusrc;
  logic        w_isBeq, w_isJmp, w_isHalt;
  logic        w_blocked, w_loadUse, w_branchDep, w_bubble;

  // Register read with write-through: a same-cycle write-back wins over the
  // stored value, except r0 which is hard-wired to zero.
  function automatic logic [15:0] readReg(input logic [3:0] addr);
    if (R0_ZERO && addr == 4'd0)
      readReg = 16'd0;
    else if (wb_we && addr == wb_addr)
      readReg = wb_data;
    else
      readReg = r_regs[addr];
  endfunction

  // A source only creates a dependency if it is really read and is not r0.
  function automatic logic srcHit(input logic valid, input logic [3:0] src,
                                  input logic [3:0] rd);
    srcHit = valid && (src == rd) && !(R0_ZERO && src == 4'd0);
  endfunction

  assign w_rOne   = readReg(one_ID);
  assign w_rTwo   = readReg(two_ID);
  assign w_rThree = readReg(three_ID);
  assign w_imm    = {{12{three_ID[3]}}, three_ID};
  assign w_isBeq  = (opcode_ID == OP_BEQ);
  assign w_isJmp  = (opcode_ID == OP_JMP);
  assign w_isHalt = (opcode_ID == OP_HALT);

  // Field decode: which fields are sources, destination and control bits.
  always_comb begin
    w_src1      = two_ID;
    w_src2      = three_ID;
    w_src1Valid = 1'b0;
    w_src2Valid = 1'b0;
    w_rd        = 4'd0;
    w_b         = w_rThree;
    w_regwrite  = 1'b0;
    w_memread   = 1'b0;
    w_memwrite  = 1'b0;
    w_alusrc    = 1'b0;
    case (opcode_ID)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        w_src1Valid = 1'b1;
        w_src2Valid = 1'b1;
        w_rd        = one_ID;
        w_regwrite  = 1'b1;
      end
      OP_ADDI: begin
        w_src1Valid = 1'b1;
        w_rd        = one_ID;
        w_regwrite  = 1'b1;
        w_alusrc    = 1'b1;
      end
      OP_LW: begin
        w_src1Valid = 1'b1;
        w_rd        = one_ID;
        w_regwrite  = 1'b1;
        w_memread   = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        w_src1      = one_ID;
        w_src2      = two_ID;
        w_src1Valid = 1'b1;
        w_src2Valid = 1'b1;
        w_b         = w_rOne;
        w_memwrite  = (opcode_ID == OP_SW);
      end
      default: ;
    endcase
  end

  // A squashed slot or a halted stage never stalls and never redirects.
  always_comb begin
    w_blocked   = r_squash || r_halt;
    w_loadUse   = ex_memread &&
                  (srcHit(w_src1Valid, w_src1, ex_rd) ||
                   srcHit(w_src2Valid, w_src2, ex_rd));
    w_branchDep = w_isBeq &&
                  ((ex_regwrite && (srcHit(w_src1Valid, w_src1, ex_rd) ||
                                    srcHit(w_src2Valid, w_src2, ex_rd))) ||
                   (mem_regwrite && (srcHit(w_src1Valid, w_src1, mem_rd) ||
                                     srcHit(w_src2Valid, w_src2, mem_rd))));
    Hazard      = !w_blocked && (w_loadUse || w_branchDep);
    w_bubble    = w_blocked || Hazard || w_isHalt;
  end

  // Redirect selection; targets are computed every cycle regardless.
  always_comb begin
    PCSource = 2'b00;
    if (!w_blocked && !Hazard) begin
      if (w_isBeq && (w_rOne == w_rTwo))
        PCSource = 2'b01;
      else if (w_isJmp)
        PCSource = 2'b10;
    end
  end

  assign PCMux_1 = PC_ID + 16'd2 + {w_imm[14:0], 1'b0};
  assign PCMux_2 = {PC_ID[15:13], one_ID, two_ID, three_ID, 1'b0};
  assign Halt    = r_halt;

  // Register file storage; r0 is never written when hard-wired to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (wb_we && !(R0_ZERO && wb_addr == 4'd0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // ID/EX register plus squash and halt flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_squash    <= 1'b0;
      r_halt      <= 1'b0;
      ex_opcode   <= 4'd0;
      ex_rd       <= 4'd0;
      ex_a        <= 16'd0;
      ex_b        <= 16'd0;
      ex_imm      <= 16'd0;
      ex_pc       <= 16'd0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
    end else begin
      r_squash <= (PCSource != 2'b00);
      if (w_isHalt && !r_squash)
        r_halt <= 1'b1;
      if (w_bubble) begin
        ex_opcode   <= OP_BUBBLE;
        ex_rd       <= 4'd0;
        ex_a        <= 16'd0;
        ex_b        <= 16'd0;
        ex_imm      <= 16'd0;
        ex_pc       <= 16'd0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_alusrc   <= 1'b0;
      end else begin
        ex_opcode   <= opcode_ID;
        ex_rd       <= w_rd;
        ex_a        <= w_rTwo;
        ex_b        <= w_b;
        ex_imm      <= w_imm;
        ex_pc       <= PC_ID;
        ex_regwrite <= w_regwrite;
        ex_memread  <= w_memread;
        ex_memwrite <= w_memwrite;
        ex_alusrc   <= w_alusrc;
      end
    end
  end

`ifdef ID_PERF_EN
  logic [15:0] r_stallCount;

  // Saturating count of cycles spent stalled on a hazard.
  always_ff @(posedge clk) begin
    if (!reset)
      r_stallCount <= 16'd0;
    else if (Hazard && r_stallCount != 16'hFFFF)
      r_stallCount <= r_stallCount + 16'd1;
  end

  assign stall_count = r_stallCount;
`else
  assign stall_count = 16'd0;
`endif

endmodule
